alu_share_arbiter: RTL and testbench

- Shares the single combinational ALU (AND/OR/ADD/SUB, 4-bit control) between two requesters, e.g. the core datapath and an auxiliary address/compare unit.
- Each requester uses a valid/ready request channel and a valid/ready response channel.
- Arbitration is round-robin; the ALU is driven from registered operands, and its result and zero flag are captured into per-requester response registers.

---
 rtl/alu_share_arbiter.sv | 141 ++++++++++++++
 tb/tb_alu_share_arbiter.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - round-robin sharing of one combinational ALU between two valid/ready requesters
module alu_share_arbiter #(
    parameter int WIDTH     = 32,
    parameter bit INIT_PRIO = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [3:0]       req0_op,
    output logic             resp0_valid,
    input  logic             resp0_ready,
    output logic [WIDTH-1:0] resp0_result,
    output logic             resp0_zero,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [3:0]       req1_op,
    output logic             resp1_valid,
    input  logic             resp1_ready,
    output logic [WIDTH-1:0] resp1_result,
    output logic             resp1_zero,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_control,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t           state_q, state_d;
    logic             prio_q, prio_d;
    logic             gnt_q, gnt_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [3:0]       op_q, op_d;
    logic             v0_q, v0_d, v1_q, v1_d;
    logic [WIDTH-1:0] res0_q, res0_d, res1_q, res1_d;
    logic             z0_q, z0_d, z1_q, z1_d;
    logic             sel;
    logic             any_req;

    // Contention is settled by the pointer; a lone requester always wins.
    assign any_req = req0_valid | req1_valid;
    assign sel     = (req0_valid && req1_valid) ? prio_q : req1_valid;

    always_comb begin
        state_d    = state_q;
        prio_d     = prio_q;
        gnt_d      = gnt_q;
        a_d        = a_q;
        b_d        = b_q;
        op_d       = op_q;
        v0_d       = v0_q;
        v1_d       = v1_q;
        res0_d     = res0_q;
        res1_d     = res1_q;
        z0_d       = z0_q;
        z1_d       = z1_q;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    req0_ready = ~sel;
                    req1_ready = sel;
                    gnt_d      = sel;
                    prio_d     = ~sel;
                    a_d        = sel ? req1_a  : req0_a;
                    b_d        = sel ? req1_b  : req0_b;
                    op_d       = sel ? req1_op : req0_op;
                    state_d    = EXEC;
                end
            end
            EXEC: begin
                if (gnt_q) begin
                    res1_d = alu_result;
                    z1_d   = alu_zero;
                    v1_d   = 1'b1;
                end else begin
                    res0_d = alu_result;
                    z0_d   = alu_zero;
                    v0_d   = 1'b1;
                end
                state_d = RESP;
            end
            RESP: begin
                if (gnt_q ? resp1_ready : resp0_ready) begin
                    v0_d    = 1'b0;
                    v1_d    = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            prio_q  <= INIT_PRIO;
            gnt_q   <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            v0_q    <= 1'b0;
            v1_q    <= 1'b0;
            res0_q  <= '0;
            res1_q  <= '0;
            z0_q    <= 1'b0;
            z1_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            gnt_q   <= gnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            v0_q    <= v0_d;
            v1_q    <= v1_d;
            res0_q  <= res0_d;
            res1_q  <= res1_d;
            z0_q    <= z0_d;
            z1_q    <= z1_d;
        end
    end

    assign alu_a        = a_q;
    assign alu_b        = b_q;
    assign alu_control  = op_q;
    assign resp0_valid  = v0_q;
    assign resp0_result = res0_q;
    assign resp0_zero   = z0_q;
    assign resp1_valid  = v1_q;
    assign resp1_result = res1_q;
    assign resp1_zero   = z1_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb/tb_alu_share_arbiter.sv - transaction-level self-checking bench for alu_share_arbiter
module tb_alu_share_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid, req0_ready, resp0_valid, resp0_ready, resp0_zero;
    logic        req1_valid, req1_ready, resp1_valid, resp1_ready, resp1_zero;
    logic [31:0] req0_a, req0_b, req1_a, req1_b, resp0_result, resp1_result;
    logic [3:0]  req0_op, req1_op, alu_control;
    logic [31:0] alu_a, alu_b, alu_result;
    logic        alu_zero;

    int checks = 0;
    int errors = 0;
    int model_prio;

    always #5 clk = ~clk;

    alu_share_arbiter #(.WIDTH(32), .INIT_PRIO(1'b0)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req0_op(req0_op), .resp0_valid(resp0_valid), .resp0_ready(resp0_ready),
        .resp0_result(resp0_result), .resp0_zero(resp0_zero),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .req1_op(req1_op), .resp1_valid(resp1_valid), .resp1_ready(resp1_ready),
        .resp1_result(resp1_result), .resp1_zero(resp1_zero),
        .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
        .alu_result(alu_result), .alu_zero(alu_zero)
    );

    // Arithmetic meaning of each control code: {zero, result}.
    function automatic logic [32:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        case (op)
            4'b0000: r = a & b;
            4'b0001: r = a | b;
            4'b0010: r = a + b;
            4'b0110: r = a - b;
            default: r = 32'd0;
        endcase
        return {(r == 32'd0), r};
    endfunction

    logic [32:0] alu_out;
    assign alu_out    = ref_alu(alu_control, alu_a, alu_b);
    assign alu_result = alu_out[31:0];
    assign alu_zero   = alu_out[32];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic resp_phase(input int w, input logic [32:0] e);
        chk("resp_valid_win", w ? resp1_valid : resp0_valid, 1);
        chk("resp_valid_other", w ? resp0_valid : resp1_valid, 0);
        chk("resp_result", w ? resp1_result : resp0_result, e[31:0]);
        chk("resp_zero", w ? resp1_zero : resp0_zero, e[32]);
        chk("req_ready_resp", {req0_ready, req1_ready}, 0);
    endtask

    // One full operation from the IDLE cycle through the response handshake.
    task automatic round(input bit v0, input bit v1,
                         input logic [31:0] a0, input logic [31:0] b0, input logic [3:0] op0,
                         input logic [31:0] a1, input logic [31:0] b1, input logic [3:0] op1,
                         input int hold);
        int w;
        logic [31:0] ea, eb;
        logic [3:0]  eo;
        logic [32:0] e;
        req0_valid = v0; req0_a = a0; req0_b = b0; req0_op = op0;
        req1_valid = v1; req1_a = a1; req1_b = b1; req1_op = op1;
        resp0_ready = (hold == 0);
        resp1_ready = (hold == 0);
        w  = (v0 && v1) ? model_prio : (v1 ? 1 : 0);
        ea = w ? a1 : a0;
        eb = w ? b1 : b0;
        eo = w ? op1 : op0;
        e  = ref_alu(eo, ea, eb);
        #1;
        chk("req0_ready_idle", req0_ready, (w == 0));
        chk("req1_ready_idle", req1_ready, (w == 1));
        @(posedge clk); #1;
        model_prio = 1 - w;
        req0_a = $urandom; req0_b = $urandom; req0_op = 4'($urandom);
        req1_a = $urandom; req1_b = $urandom; req1_op = 4'($urandom);
        #1;
        chk("req_ready_exec", {req0_ready, req1_ready}, 0);
        chk("resp_valid_exec", {resp0_valid, resp1_valid}, 0);
        chk("alu_a_exec", alu_a, ea);
        chk("alu_b_exec", alu_b, eb);
        chk("alu_control_exec", alu_control, eo);
        @(posedge clk); #1;
        for (int k = 0; k < hold; k++) begin
            resp_phase(w, e);
            @(posedge clk); #1;
        end
        if (w) resp1_ready = 1'b1; else resp0_ready = 1'b1;
        #1;
        resp_phase(w, e);
        @(posedge clk); #1;
        chk("resp_valid_cleared", {resp0_valid, resp1_valid}, 0);
    endtask

    initial begin
        logic [3:0]  ops [5];
        logic [31:0] ra0, rb0, ra1, rb1;
        bit          rv0, rv1;
        model_prio = 0;
        reset = 1'b1;
        req0_valid = 0; req1_valid = 0; resp0_ready = 0; resp1_ready = 0;
        req0_a = 0; req0_b = 0; req0_op = 0; req1_a = 0; req1_b = 0; req1_op = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_resp_valid", {resp0_valid, resp1_valid}, 0);
        chk("reset_results", resp0_result | resp1_result, 0);
        chk("reset_alu_a", alu_a, 0);
        chk("reset_alu_ctl", {alu_b[3:0] | alu_control, resp0_zero, resp1_zero}, 0);
        reset = 1'b0;

        round(1, 0, 32'd5, 32'd3, 4'b0010, 0, 0, 0, 0);
        round(1, 1, 32'hF0F0, 32'h0F0F, 4'b0000, 32'd7, 32'd7, 4'b0110, 0);
        round(1, 1, 32'hF0F0, 32'h0F0F, 4'b0000, 32'd7, 32'd7, 4'b0110, 0);
        round(1, 1, 32'd1, 32'd2, 4'b0010, 32'd9, 32'd4, 4'b0110, 0);
        round(0, 1, 0, 0, 0, 32'h00FF, 32'hFF00, 4'b0001, 5);
        round(1, 0, 32'hFFFF_FFFF, 32'd1, 4'b0010, 0, 0, 0, 0);
        round(1, 0, 32'd9, 32'd9, 4'b1111, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++)
            round(1, 0, 32'd100 * i, 32'd7, 4'b0110, 0, 0, 0, 0);

        // Abort in EXEC: reset wins over the capture edge.
        req0_valid = 0; req1_valid = 1; req1_a = 32'd10; req1_b = 32'd4; req1_op = 4'b0110;
        resp1_ready = 1;
        #1;
        chk("abort_accept", req1_ready, 1);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        model_prio = 0;
        chk("abort_no_resp", {resp0_valid, resp1_valid}, 0);
        chk("abort_result", resp1_result, 0);
        chk("abort_alu_a", alu_a, 0);
        chk("abort_alu_ctl", alu_control, 0);
        round(1, 1, 32'd3, 32'd3, 4'b0110, 32'd1, 32'd1, 4'b0001, 0);

        ops[0] = 4'b0000; ops[1] = 4'b0001; ops[2] = 4'b0010; ops[3] = 4'b0110; ops[4] = 4'b0000;
        for (int i = 0; i < 40; i++) begin
            ops[4] = 4'($urandom_range(0, 15));
            rv0 = 1'($urandom); rv1 = 1'($urandom);
            if (!rv0 && !rv1) rv0 = 1'b1;
            ra0 = $urandom; ra1 = $urandom;
            rb0 = ($urandom_range(0, 3) == 0) ? ra0 : $urandom;
            rb1 = ($urandom_range(0, 3) == 0) ? ra1 : $urandom;
            round(rv0, rv1, ra0, rb0, ops[$urandom_range(0, 4)],
                  ra1, rb1, ops[$urandom_range(0, 4)], $urandom_range(0, 3));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
